// File: rtl/ad5791_readback.sv
// Read-back engine for four AD5791 DACs: sends a read command frame, then a NOP
// frame while capturing SDO, and returns the captured word on an AXI-Stream port.
module ad5791_readback #(
  parameter int SCLK_DIV = 4,
  parameter int SYNC_GAP = 4
) (
  input  logic        a_clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [1:0]  rd_axis,
  input  logic [2:0]  rd_addr,
  output logic        rd_ready,
  output logic [31:0] M_AXIS_tdata,
  output logic        M_AXIS_tvalid,
  input  logic        M_AXIS_tready,
  output logic        busy,
  output logic        dac_sclk,
  output logic        dac_sdin,
  output logic [3:0]  dac_syncn,
  input  logic [3:0]  dac_sdo
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int GW = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_GAP  = 3'd2,
    S_NOP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic addr_err(input logic [23:0] frame, input logic [2:0] addr);
    return (frame[22:20] != addr);
  endfunction

  function automatic logic [3:0] sync_mask(input logic [1:0] axis);
    return ~(4'b0001 << axis);
  endfunction

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic           half_q, half_d;
  logic [4:0]     bit_q, bit_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [23:0]    tx_q, tx_d;
  logic [23:0]    rx_q, rx_d;
  logic [1:0]     axis_q, axis_d;
  logic [2:0]     addr_q, addr_d;
  logic           sclk_q, sclk_d;
  logic           sdin_q, sdin_d;
  logic [3:0]     syncn_q, syncn_d;
  logic           tvalid_q, tvalid_d;
  logic [31:0]    tdata_q, tdata_d;
  logic           ready_q, ready_d;

  logic           sdo_bit;
  logic           last_tick;
  logic           end_of_bit;
  logic           serial;

  // Next-state, counters, shifters and registered-output values
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    axis_d     = axis_q;
    addr_d     = addr_q;
    tdata_d    = tdata_q;
    sdo_bit    = dac_sdo[axis_q];
    last_tick  = (div_q == DIV_LAST);
    end_of_bit = half_q && last_tick;

    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          state_d = S_CMD;
          axis_d  = rd_axis;
          addr_d  = rd_addr;
          tx_d    = {1'b1, rd_addr, 20'h00000};
          rx_d    = 24'h000000;
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CMD, S_NOP: begin
        if (last_tick) begin
          div_d  = '0;
          half_d = !half_q;
        end else begin
          div_d  = div_q + DW'(1);
        end
        // SDO is sampled on the final cycle of the low half, just before SCLK rises
        if (end_of_bit) begin
          rx_d = {rx_q[22:0], sdo_bit};
          tx_d = {tx_q[22:0], 1'b0};
          if (bit_q == 5'd23) begin
            bit_d = 5'd0;
            if (state_q == S_CMD) begin
              state_d = S_GAP;
              gap_d   = '0;
              rx_d    = 24'h000000;
            end else begin
              state_d = S_DONE;
              tdata_d = {axis_q, addr_err(rx_d, addr_q), 5'd0, rx_d};
            end
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          bit_d = bit_q;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_NOP;
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = 5'd0;
          tx_d    = 24'h000000;
        end else begin
          gap_d   = gap_q + GW'(1);
        end
      end

      S_DONE: begin
        if (tvalid_q && M_AXIS_tready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    serial   = (state_d == S_CMD) || (state_d == S_NOP);
    sclk_d   = serial ? !half_d : 1'b1;
    sdin_d   = serial ? tx_d[23] : 1'b0;
    syncn_d  = serial ? sync_mask(axis_d) : 4'hF;
    tvalid_d = (state_d == S_DONE);
    ready_d  = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge a_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      half_q   <= 1'b0;
      bit_q    <= 5'd0;
      gap_q    <= '0;
      tx_q     <= 24'h000000;
      rx_q     <= 24'h000000;
      axis_q   <= 2'd0;
      addr_q   <= 3'd0;
      sclk_q   <= 1'b1;
      sdin_q   <= 1'b0;
      syncn_q  <= 4'hF;
      tvalid_q <= 1'b0;
      tdata_q  <= 32'h00000000;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      axis_q   <= axis_d;
      addr_q   <= addr_d;
      sclk_q   <= sclk_d;
      sdin_q   <= sdin_d;
      syncn_q  <= syncn_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      ready_q  <= ready_d;
    end
  end

  assign rd_ready      = ready_q;
  assign busy          = !ready_q;
  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tdata  = tdata_q;
  assign dac_sclk      = sclk_q;
  assign dac_sdin      = sdin_q;
  assign dac_syncn     = syncn_q;

endmodule

// File: tb/tb_ad5791_readback.sv
// Self-checking bench: instance 0 uses default timing, instance 1 the fastest
// (SCLK_DIV=1, SYNC_GAP=1). A behavioural DAC model answers NOP frames on SDO.
module tb_ad5791_readback;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        req    [2];
  logic [1:0]  axis   [2];
  logic [2:0]  addr   [2];
  logic        tready [2];
  logic        rdy    [2];
  logic [31:0] tdata  [2];
  logic        tvalid [2];
  logic        busy   [2];
  logic        sclk   [2];
  logic        sdin   [2];
  logic [3:0]  syncn  [2];
  logic [3:0]  sdo    [2] = '{4'h0, 4'h0};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ad5791_readback #(
      .SCLK_DIV((g == 0) ? 4 : 1),
      .SYNC_GAP((g == 0) ? 4 : 1)
    ) u_dut (
      .a_clk(clk), .reset(rst[g]), .rd_req(req[g]), .rd_axis(axis[g]),
      .rd_addr(addr[g]), .rd_ready(rdy[g]), .M_AXIS_tdata(tdata[g]),
      .M_AXIS_tvalid(tvalid[g]), .M_AXIS_tready(tready[g]), .busy(busy[g]),
      .dac_sclk(sclk[g]), .dac_sdin(sdin[g]), .dac_syncn(syncn[g]), .dac_sdo(sdo[g])
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference rules
  function automatic int div_of(input int g);  return (g == 0) ? 4 : 1; endfunction
  function automatic int gap_of(input int g);  return (g == 0) ? 4 : 1; endfunction
  function automatic int exp_latency(input int g);
    return 96 * div_of(g) + gap_of(g) + 1;
  endfunction
  function automatic logic [31:0] exp_result(input logic [1:0] ax, input logic [2:0] ad,
                                              input logic [23:0] val);
    logic err;
    err = (val[22:20] != ad);
    return {ax, err, 5'd0, val};
  endfunction
  function automatic logic [23:0] exp_cmd(input logic [2:0] ad);
    return {1'b1, ad, 20'h00000};
  endfunction

  // DAC model settings (written by stimulus only)
  logic [23:0] dac_reply [2];
  logic [1:0]  mon_axis  [2];
  logic [3:0]  exp_mask  [2] = '{4'hE, 4'hE};
  int          nop_idx   [2] = '{-1, -1};

  // DAC model state (written by the model only)
  int          fcount    [2] = '{0, 0};
  int          bitn      [2] = '{0, 0};
  int          falls     [2] = '{0, 0};
  int          sync_bad  [2] = '{0, 0};
  logic [23:0] shreg     [2] = '{24'h0, 24'h0};
  logic [23:0] cmd_word  [2] = '{24'h0, 24'h0};
  logic        prev_sclk [2] = '{1'b1, 1'b1};
  logic [3:0]  prev_sync [2] = '{4'hF, 4'hF};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prev_sync[i] == 4'hF && syncn[i] != 4'hF) begin
        fcount[i]++;
        bitn[i]  = 0;
        shreg[i] = 24'h0;
      end
      if (syncn[i] != 4'hF && syncn[i] != exp_mask[i]) sync_bad[i]++;
      if (prev_sclk[i] && !sclk[i]) begin
        falls[i]++;
        if (syncn[i] != 4'hF && bitn[i] < 24) begin
          shreg[i] = {shreg[i][22:0], sdin[i]};
          sdo[i] = 4'($urandom);
          if (fcount[i] == nop_idx[i]) sdo[i][mon_axis[i]] = dac_reply[i][23 - bitn[i]];
          bitn[i]++;
          if (bitn[i] == 24 && fcount[i] == nop_idx[i] - 1) cmd_word[i] = shreg[i];
        end
      end
      prev_sclk[i] = sclk[i];
      prev_sync[i] = syncn[i];
    end
  end

  // Issue a request; returns at the first negedge after the accepting edge
  task automatic start_req(input int g, input logic [1:0] ax, input logic [2:0] ad,
                           input logic [23:0] val);
    dac_reply[g] = val;
    mon_axis[g]  = ax;
    exp_mask[g]  = ~(4'b0001 << ax);
    nop_idx[g]   = fcount[g] + 2;
    @(negedge clk);
    check("ready_before_req", 32'(rdy[g]), 32'd1);
    req[g] = 1'b1; axis[g] = ax; addr[g] = ad;
    @(negedge clk);
    req[g] = 1'b0;
    check("busy_after_accept", 32'(busy[g]), 32'd1);
  endtask

  task automatic do_read(input int g, input logic [1:0] ax, input logic [2:0] ad,
                         input logic [23:0] val, input int hold);
    int n;
    int bad0;
    int f0;
    int unstable;
    logic [31:0] held;
    bad0 = sync_bad[g];
    start_req(g, ax, ad, val);
    n = 1;
    while (!tvalid[g] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tvalid_latency", 32'(n), 32'(exp_latency(g)));
    check("result_tdata", tdata[g], exp_result(ax, ad, val));
    check("cmd_frame", {8'd0, cmd_word[g]}, {8'd0, exp_cmd(ad)});
    check("other_syncn_quiet", 32'(sync_bad[g] - bad0), 32'd0);
    if (hold > 0) begin
      f0 = falls[g];
      held = tdata[g];
      unstable = 0;
      for (int k = 0; k < hold; k++) begin
        tready[g] = 1'b0;
        req[g] = (k == hold / 2);
        axis[g] = 2'($urandom);
        @(negedge clk);
        if (tdata[g] !== held || tvalid[g] !== 1'b1) unstable++;
      end
      req[g] = 1'b0;
      check("hold_stable", 32'(unstable), 32'd0);
      check("hold_no_sclk", 32'(falls[g] - f0), 32'd0);
      check("hold_not_ready", 32'(rdy[g]), 32'd0);
    end
    tready[g] = 1'b1;
    @(negedge clk);
    tready[g] = 1'b0;
    check("tvalid_drop", 32'(tvalid[g]), 32'd0);
    check("ready_after_hs", 32'(rdy[g]), 32'd1);
    check("busy_after_hs", 32'(busy[g]), 32'd0);
  endtask

  task automatic rand_read(input int g);
    logic [1:0]  ax;
    logic [2:0]  ad;
    logic [23:0] val;
    ax  = 2'($urandom_range(0, 3));
    ad  = 3'($urandom_range(0, 7));
    val = 24'($urandom);
    if ($urandom_range(0, 1) == 1) val[22:20] = ad;
    do_read(g, ax, ad, val, int'($urandom_range(0, 5)));
  endtask

  initial begin
    int n;
    int seen;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; axis[i] = 2'd0; addr[i] = 3'd0;
      tready[i] = 1'b0; dac_reply[i] = 24'h0; mon_axis[i] = 2'd0;
    end
    repeat (5) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_syncn", 32'(syncn[i]), 32'hF);
      check("rst_sclk", 32'(sclk[i]), 32'd1);
      check("rst_sdin", 32'(sdin[i]), 32'd0);
      check("rst_tvalid", 32'(tvalid[i]), 32'd0);
      check("rst_tdata", tdata[i], 32'h0);
      check("rst_ready", 32'(rdy[i]), 32'd1);
      check("rst_busy", 32'(busy[i]), 32'd0);
    end

    do_read(0, 2'd2, 3'd1, 24'h1ABCDE, 0);
    do_read(0, 2'd0, 3'd2, 24'h300000, 50);

    // Abort a read mid-frame with reset
    start_req(0, 2'd1, 3'd5, 24'h5A5A5A);
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_frame_active", 32'(syncn[0] == 4'hF), 32'd0);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_syncn", 32'(syncn[0]), 32'hF);
    check("abort_sclk", 32'(sclk[0]), 32'd1);
    check("abort_tvalid", 32'(tvalid[0]), 32'd0);
    check("abort_ready", 32'(rdy[0]), 32'd1);
    rst[0] = 1'b0;
    seen = 0;
    repeat (450) begin
      @(negedge clk);
      if (tvalid[0] || syncn[0] != 4'hF) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    do_read(0, 2'd1, 3'd5, 24'h5A5A5A, 0);

    do_read(1, 2'd3, 3'd4, 24'hC00001, 0);
    for (int k = 0; k < 4; k++) rand_read(1);
    for (int k = 0; k < 3; k++) rand_read(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
